dff_bank_arb: RTL and testbench
===============================

# dff_bank_arb

Round-robin write-port arbiter for the shared register bank built from `dff` cells. Up to N requesters compete for the bank's single write port. Each winning request produces a one-cycle registered grant together with the bank write strobe, address and data. The block sits between the requesting blocks and the bank and is the only driver of the bank write port.

## Interface
Parameters:
- `N`, 4 — number of requesters (2..8).
- `W`, 8 — bank data width.
- `AW`, 2 — bank address width (bank depth 2^AW).
- `HOLD_MAX`, 15 — maximum consecutive locked grants to one requester (1..255).

Ports:
- `C` input 1 — clock; all state updates on rising edge.
- `nR` input 1 — reset; one clock, reset is synchronous and active-low.
- `req` input N — per-requester write request, level.
- `lock` input N — per-requester burst lock; only meaningful with `DFF_ARB_LOCK_EN`.
- `addr` input N*AW — requester i's address in bits [i*AW +: AW].
- `data` input N*W — requester i's data in bits [i*W +: W].
- `gnt` output N — one-hot grant pulse, registered.
- `bank_we` output 1 — bank write strobe, registered; equals |gnt.
- `bank_addr` output AW — registered write address.
- `bank_d` output W — registered write data.
- `busy` output 1 — high while a lock burst is in progress.

## Operation
- **Reset.** While `nR`=0 at a rising edge, all of the following clear:
  - `gnt`, `bank_we`, `busy` = 0.
  - `bank_addr`, `bank_d` = 0.
  - Round-robin pointer `last` = N-1, so requester 0 has first priority after reset.
  - Burst counter = 0; FSM = IDLE.
- **Eligibility** at each edge:
  - Requester i is eligible if `req[i]`=1 and `gnt[i]` is not currently 1.
  - Exception: the current burst owner is eligible while its grant is high (see BURST).
- **Selection.** Search starts at `last`+1 (mod N) and takes the first eligible requester. On a grant, `last` updates to the winner's index.
- **Grant capture.** Register `gnt`=onehot(winner), `bank_we`=1, and capture `bank_addr`/`bank_d` from the winner's slices. With no eligible requester: `gnt`=0, `bank_we`=0, `bank_addr`/`bank_d` hold their previous values.
- **FSM states:**
  - IDLE — normal arbitration.
  - BURST — exists only with `DFF_ARB_LOCK_EN`.
- **IDLE → BURST:** winner has `lock`=1. Counter loads 1; `busy`=1.
- **In BURST, owner o:**
  - If `req[o]`=1 and `lock[o]`=1 and counter < `HOLD_MAX`: grant o again (back-to-back), counter +1.
  - Otherwise, if counter = `HOLD_MAX` with other requesters pending, or `lock[o]`=0, or `req[o]`=0: return to IDLE, `busy`=0, and arbitrate normally in the same edge. o is ineligible that edge if `gnt[o]` is high.
- **Counter width.** Counter is ceil(log2(HOLD_MAX+1)) bits. It never wraps: it saturates at `HOLD_MAX`, which forces exit. If no other requester is pending at `HOLD_MAX`, o may re-enter BURST after one idle cycle.
- **Requester contract.**
  - Hold `req`, `addr` and `data` stable until `gnt[i]` is observed.
  - Deassert `req` or present the next word in the `gnt` cycle.
  - Changing `addr`/`data` while waiting is legal; the values captured are those present at the edge that produces the grant.
- **Reset mid-burst.** Aborts immediately and applies reset values; no partial write is issued.

## Timing
- **Latency.** Request sampled at edge k produces `gnt`/`bank_we` high in cycle k→k+1. That is 1 cycle from a registered `req`.
- **Throughput without lock:** one grant per cycle across requesters. A single requester gets at most one grant every 2 cycles.
- **Throughput with lock:** one grant per cycle for the owner, up to `HOLD_MAX` consecutive.
- `gnt` is always one-hot or zero.
- `bank_we`, `bank_addr` and `bank_d` change only on `C` edges; they are glitch-free for the `#1` output stages of `dff`.
- **Starvation bound:** a requester holding `req` is granted within (N-1)·`HOLD_MAX` + N cycles.

## Configuration
- `DFF_ARB_LOCK_EN` defined:
  - `lock` input is honoured.
  - BURST state and burst counter are present.
  - `busy` behaves as above.
- `DFF_ARB_LOCK_EN` undefined:
  - `lock` is ignored; no BURST state or counter is synthesized.
  - `busy` is tied 0.
  - Every grant is single-cycle round-robin.

## Test plan
- **Reset:** hold `nR`=0 for 3 edges with `req`=4'b1111 → `gnt`=0, `bank_we`=0, `bank_addr`=0, `bank_d`=0, `busy`=0. Release → first `gnt`=4'b0001.
- **Round-robin:** `req`=4'b1111 held, no lock, `data[i]`=8'hA0+i → grant sequence 0001,0010,0100,1000,0001 on consecutive cycles; `bank_d` = A0,A1,A2,A3,A0.
- **Single requester:** only `req[2]`=1 held, `addr[2]`=2'd3 → `gnt[2]` pulses every other cycle with `bank_addr`=3; `bank_we` is never high two cycles in a row.
- **Lock burst (`DFF_ARB_LOCK_EN`, `HOLD_MAX`=3):** `req`=4'b0011, `lock[0]`=1 → `gnt[0]` for 3 consecutive cycles with `busy`=1, then `gnt[1]`=1 and `busy`=0.
- **Reset mid-burst:** `nR`=0 during the second locked grant → next cycle `gnt`=0, `busy`=0. After release, priority restarts at requester 0.
- **Lock compiled out:** same stimulus as the lock-burst test with `DFF_ARB_LOCK_EN` undefined → alternating `gnt` 0001/0010; `busy` stays 0.

Source files
------------

// File: rtl/dff_bank_arb.sv
// dff_bank_arb: round-robin arbiter driving the single write port of a dff register bank
// Ports: C clock, nR sync active-low reset, req/lock per-requester, addr/data packed per requester,
//        gnt one-hot registered grant, bank_we/bank_addr/bank_d registered write port, busy burst flag.
// Optional lock bursts are built only when DFF_ARB_LOCK_EN is defined.
module dff_bank_arb #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int AW = 2,
  parameter int HOLD_MAX = 15
) (
  input  logic            C,
  input  logic            nR,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N*AW-1:0] addr,
  input  logic [N*W-1:0]  data,
  output logic [N-1:0]    gnt,
  output logic            bank_we,
  output logic [AW-1:0]   bank_addr,
  output logic [W-1:0]    bank_d,
  output logic            busy
);
  localparam int LW = N > 1 ? $clog2(N) : 1;
  logic [LW-1:0] last, win, pick;
  logic [N-1:0] elig;
  logic found, take;
  // A requester whose grant is showing this cycle sits out one edge.
  always_comb begin
    elig = req & ~gnt;
    win = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && elig[(int'(last) + k) % N]) begin
        found = 1'b1;
        win = LW'((int'(last) + k) % N);
      end
    end
  end
`ifdef DFF_ARB_LOCK_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic hold;
  // The burst owner is always last, since last tracks the most recent winner.
  always_comb begin
    hold = state == BURST && req[last] && lock[last] && cnt < CW'(HOLD_MAX);
    take = hold | found;
    pick = hold ? last : win;
    state_n = hold ? BURST : (found && lock[win]) ? BURST : IDLE;
    cnt_n = hold ? cnt + CW'(1) : (found && lock[win]) ? CW'(1) : '0;
  end
  always_ff @(posedge C) begin
    if (!nR) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  assign busy = state == BURST;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign take = found;
  assign pick = win;
  assign busy = 1'b0;
`endif
  always_ff @(posedge C) begin
    if (!nR) begin
      gnt <= '0;
      bank_we <= 1'b0;
      bank_addr <= '0;
      bank_d <= '0;
      last <= LW'(N - 1);
    end else begin
      gnt <= take ? N'(1) << pick : '0;
      bank_we <= take;
      if (take) begin
        bank_addr <= addr[int'(pick)*AW +: AW];
        bank_d <= data[int'(pick)*W +: W];
        last <= pick;
      end
    end
  end
endmodule

// File: tb/tb_dff_bank_arb.sv
// tb_dff_bank_arb: scoreboard bench for dff_bank_arb with directed vectors
module tb_dff_bank_arb;
  logic C, nR;
  logic [3:0] req, lock, gnt;
  logic [7:0] addr;
  logic [31:0] data;
  logic bank_we, busy;
  logic [1:0] bank_addr;
  logic [7:0] bank_d;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c;
  typedef struct {
    int cyc;
    logic [3:0] g;
    logic [1:0] a;
    logic [7:0] d;
    logic b;
  } exp_t;
  exp_t q[$];
  dff_bank_arb #(.N(4), .W(8), .AW(2), .HOLD_MAX(3)) dut (
    .C(C), .nR(nR), .req(req), .lock(lock), .addr(addr), .data(data),
    .gnt(gnt), .bank_we(bank_we), .bank_addr(bank_addr), .bank_d(bank_d), .busy(busy)
  );
  initial C = 1'b0;
  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;
`ifdef DFF_ARB_LOCK_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", n, cyc, act, exp);
    end
  endtask
  task automatic push(input int cc, input logic [3:0] g, input logic [1:0] a, input logic [7:0] d, input logic b);
    exp_t e;
    e.cyc = cc;
    e.g = g;
    e.a = a;
    e.d = d;
    e.b = b;
    q.push_back(e);
  endtask
  always @(negedge C) begin
    exp_t e;
    if (bank_we === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant cyc=%0d actual gnt=%b expected none", cyc, gnt);
      end else begin
        e = q.pop_front();
        chk("grant_cycle", cyc, e.cyc);
        chk("gnt", 32'(gnt), 32'(e.g));
        chk("bank_addr", 32'(bank_addr), 32'(e.a));
        chk("bank_d", 32'(bank_d), 32'(e.d));
        chk("busy", 32'(busy), 32'(e.b));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_grant cyc=%0d actual gnt=%b expected %b", cyc, gnt, q[0].g);
      void'(q.pop_front());
    end
  end
  initial begin
    nR = 1'b0;
    req = 4'b1111;
    lock = 4'b0000;
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    addr = {2'd3, 2'd2, 2'd1, 2'd0};
    repeat (3) @(posedge C);
    @(negedge C);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_we", 32'(bank_we), 0);
    chk("rst_addr", 32'(bank_addr), 0);
    chk("rst_d", 32'(bank_d), 0);
    chk("rst_busy", 32'(busy), 0);
    nR = 1'b1;
    c = cyc;
    push(c + 1, 4'b0001, 2'd0, 8'hA0, 1'b0);
    push(c + 2, 4'b0010, 2'd1, 8'hA1, 1'b0);
    push(c + 3, 4'b0100, 2'd2, 8'hA2, 1'b0);
    push(c + 4, 4'b1000, 2'd3, 8'hA3, 1'b0);
    push(c + 5, 4'b0001, 2'd0, 8'hA0, 1'b0);
    repeat (5) @(negedge C);
    req = 4'b0000;
    @(negedge C);
    addr[5:4] = 2'd3;
    req = 4'b0100;
    c = cyc;
    push(c + 1, 4'b0100, 2'd3, 8'hA2, 1'b0);
    push(c + 3, 4'b0100, 2'd3, 8'hA2, 1'b0);
    push(c + 5, 4'b0100, 2'd3, 8'hA2, 1'b0);
    repeat (5) @(negedge C);
    req = 4'b0000;
    repeat (2) @(negedge C);
    chk("idle_hold_addr", 32'(bank_addr), 3);
    chk("idle_hold_d", 32'(bank_d), 32'hA2);
    chk("idle_gnt", 32'(gnt), 0);
    req = 4'b0011;
    lock = 4'b0001;
    c = cyc;
    if (LK) begin
      push(c + 1, 4'b0001, 2'd0, 8'hA0, 1'b1);
      push(c + 2, 4'b0001, 2'd0, 8'hA0, 1'b1);
      push(c + 3, 4'b0001, 2'd0, 8'hA0, 1'b1);
      push(c + 4, 4'b0010, 2'd1, 8'hA1, 1'b0);
    end else begin
      push(c + 1, 4'b0001, 2'd0, 8'hA0, 1'b0);
      push(c + 2, 4'b0010, 2'd1, 8'hA1, 1'b0);
      push(c + 3, 4'b0001, 2'd0, 8'hA0, 1'b0);
      push(c + 4, 4'b0010, 2'd1, 8'hA1, 1'b0);
    end
    repeat (4) @(negedge C);
    req = 4'b0000;
    lock = 4'b0000;
    repeat (2) @(negedge C);
    chk("post_burst_busy", 32'(busy), 0);
    req = 4'b0011;
    lock = 4'b0001;
    c = cyc;
    push(c + 1, 4'b0001, 2'd0, 8'hA0, LK);
    if (LK) push(c + 2, 4'b0001, 2'd0, 8'hA0, 1'b1);
    else push(c + 2, 4'b0010, 2'd1, 8'hA1, 1'b0);
    repeat (2) @(negedge C);
    nR = 1'b0;
    @(negedge C);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_we", 32'(bank_we), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", 32'(bank_addr), 0);
    chk("midrst_d", 32'(bank_d), 0);
    nR = 1'b1;
    req = 4'b0111;
    lock = 4'b0000;
    c = cyc;
    push(c + 1, 4'b0001, 2'd0, 8'hA0, 1'b0);
    @(negedge C);
    req = 4'b0000;
    repeat (3) @(negedge C);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
